serial_add_ctrl: RTL and testbench

Bit-serial adder controller: sequences a single full-adder cell over a WIDTH-bit operand pair, LSB first, one bit per clock. It trades latency for area and is the shared-datapath alternative to the ripple and lookahead adders in Arithmetic_Circuits/Adders. A start/busy/done handshake launches each addition, and results are held stable until the next one completes.

---
 rtl/serial_add_ctrl_pkg.sv | 20 ++
 rtl/serial_add_ctrl_fa.sv | 14 +
 rtl/serial_add_ctrl.sv | 139 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding
// and the full-adder equation used by the single shared adder cell.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Returns {carry_out, sum_bit} of one full-adder cell.
  function automatic logic [1:0] fa_eval(input logic a, input logic b, input logic c);
    logic s;
    logic co;
    s  = a ^ b ^ c;
    co = (a & b) | (c & (a ^ b));
    return {co, s};
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// Single full-adder cell shared across all bit positions of the serial adder.
module serial_add_ctrl_fa
  import serial_add_ctrl_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign {cout, s} = fa_eval(a, b, cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: feeds one full-adder cell LSB first, one bit per
// clock, and presents a registered {cout,sum} with a start/busy/done handshake.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // One extra bit keeps WIDTH-1 representable even when WIDTH is 1.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e           state_r;
  state_e           state_nx_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] acc_nx_s;
  logic [WIDTH-1:0] sum_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic             cout_r;
  logic             busy_r;
  logic             done_r;
  logic             accept_s;
  logic             last_s;
  logic             fa_s_s;
  logic             fa_c_s;

  serial_add_ctrl_fa u_fa (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .cin  (carry_r),
    .s    (fa_s_s),
    .cout (fa_c_s)
  );

  // Next-state decode; start is only accepted from IDLE or DONE.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    last_s     = (cnt_r == LAST_CNT);
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          accept_s   = 1'b1;
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (start) begin
          accept_s   = 1'b1;
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Accumulator after this cycle's sum bit enters at the MSB.
  always_comb begin
    acc_nx_s            = acc_r >> 1;
    acc_nx_s[WIDTH-1]   = fa_s_s;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Operand shifters, carry flop, bit counter and held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      acc_r   <= {WIDTH{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      // Flags follow the next state so they line up with state_r after the edge.
      busy_r <= (state_nx_s == ST_RUN);
      done_r <= (state_nx_s == ST_DONE);
      if (accept_s) begin
        a_sh_r  <= a;
        b_sh_r  <= b;
        carry_r <= cin;
        cnt_r   <= {CW{1'b0}};
      end else if (state_r == ST_RUN) begin
        a_sh_r  <= a_sh_r >> 1;
        b_sh_r  <= b_sh_r >> 1;
        acc_r   <= acc_nx_s;
        carry_r <= fa_c_s;
        cnt_r   <= cnt_r + CW'(1);
        if (last_s) begin
          sum_r  <= acc_nx_s;
          cout_r <= fa_c_s;
        end
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: WIDTH=8 random and directed traffic,
// plus exhaustive sweeps of WIDTH=1 and WIDTH=2 instances.
module tb_serial_add_ctrl;

  localparam int W  = 8;
  localparam int W1 = W + 1;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cin   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  logic       st_s = 1'b0;
  logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0, c2 = 1'b0;
  logic [1:0] a2 = 2'd0, b2 = 2'd0;
  logic       bz1, dn1, s1, co1, bz2, dn2, co2;
  logic [1:0] s2;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout));

  serial_add_ctrl #(.WIDTH(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .start(st_s), .a(a1), .b(b1), .cin(c1),
    .busy(bz1), .done(dn1), .sum(s1), .cout(co1));

  serial_add_ctrl #(.WIDTH(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .start(st_s), .a(a2), .b(b2), .cin(c2),
    .busy(bz2), .done(dn2), .sum(s2), .cout(co2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [W:0] val;
    int         acc;
  } txn_t;

  txn_t       sb[$];
  logic [W:0] hold = '0;

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: expected busy/done/result derived from accepted-start times.
  always @(negedge clk) begin
    logic bexp;
    logic dexp;
    if (rst_n) begin
      bexp = (sb.size() > 0) && (cyc >= sb[0].acc) && (cyc < sb[0].acc + W);
      dexp = (sb.size() > 0) && (cyc == sb[0].acc + W);
      chk("busy", W1'(busy), W1'(bexp));
      chk("done", W1'(done), W1'(dexp));
      if (dexp) begin
        hold = sb[0].val;
        void'(sb.pop_front());
      end
      chk("result", {cout, sum}, hold);
    end
  end

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic cv, input bit keep);
    int t = 0;
    @(negedge clk);
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_wait: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    a = av; b = bv; cin = cv; start = 1'b1;
    sb.push_back('{val: {1'b0, av} + {1'b0, bv} + W1'(cv), acc: cyc + 1});
    if (!keep) begin
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_busy", W1'(busy), '0);
    chk("rst_done", W1'(done), '0);
    chk("rst_sum_cout", {cout, sum}, '0);
    sb.delete();
    hold = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic small_sweep();
    for (int i = 0; i < 32; i++) begin
      bit got1 = 1'b0;
      bit got2 = 1'b0;
      logic [4:0] iv;
      iv = 5'(i);
      @(negedge clk);
      a2 = iv[4:3]; b2 = iv[2:1]; c2 = iv[0];
      a1 = iv[2];   b1 = iv[1];   c1 = iv[0];
      st_s = 1'b1;
      @(negedge clk);
      st_s = 1'b0;
      for (int t = 0; t < 6; t++) begin
        if (dn1 && !got1) begin
          got1 = 1'b1;
          chk("w1_sum", W1'({co1, s1}), W1'(32'(a1) + 32'(b1) + 32'(c1)));
          chk("w1_latency", W1'(t), W1'(1));
        end
        if (dn2 && !got2) begin
          got2 = 1'b1;
          chk("w2_sum", W1'({co2, s2}), W1'(32'(a2) + 32'(b2) + 32'(c2)));
          chk("w2_latency", W1'(t), W1'(2));
        end
        @(negedge clk);
      end
      chk("small_done_seen", W1'({got1, got2}), W1'(2'b11));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    apply_reset();
    repeat (5) @(negedge clk);

    issue(8'h3C, 8'h5A, 1'b0, 1'b0);
    issue(8'hFF, 8'h01, 1'b0, 1'b0);
    issue(8'hFF, 8'hFF, 1'b1, 1'b0);
    issue(8'h00, 8'h00, 1'b1, 1'b0);

    // Start pulsed mid-RUN with other operands must be ignored.
    issue(8'h12, 8'h34, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    a = 8'hAA; b = 8'h77; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Start held through DONE gives back-to-back additions.
    issue(8'h01, 8'h02, 1'b0, 1'b1);
    repeat (W + 1) @(negedge clk);
    sb.push_back('{val: 9'h003, acc: cyc + 1});
    @(negedge clk);
    start = 1'b0;

    // Reset during RUN aborts, then a fresh addition works.
    issue(8'hC3, 8'h81, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    #2 apply_reset();
    issue(8'h10, 8'h20, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        repeat (2) @(negedge clk);
        start = 1'b1; a = W'($urandom); b = W'($urandom);
        @(negedge clk);
        start = 1'b0;
      end
    end

    repeat (W + 4) @(negedge clk);
    chk("sb_drained", W1'(sb.size()), '0);
    small_sweep();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
